// File: rtl/regex_cpu_pipelined.sv
// regex_cpu_pipelined: pipelined execution core of the regex engine.
// A thread {pc, cc_id} enters the fetch register F, its instruction is
// requested from instruction memory, captured one cycle later into the
// execute register E, executed against the character of its context, and
// its successors are pushed into a small output FIFO.
// Optional feature macro: REGEX_CPU_ACCEPT_PARTIAL_EN (opcode 110 accepts
// unconditionally when defined, otherwise it ends the thread silently).
module regex_cpu_pipelined #(
    parameter int PC_WIDTH              = 9,
    parameter int CHARACTER_WIDTH       = 8,
    parameter int MEMORY_WIDTH          = 16,
    parameter int MEMORY_ADDR_WIDTH     = 11,
    parameter int FIFO_WIDTH_POWER_OF_2 = 2,
    parameter int CC_ID_BITS            = 2
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic [(2**CC_ID_BITS)*CHARACTER_WIDTH-1:0]   current_characters,
    input  logic [(2**CC_ID_BITS)-1:0]                   end_of_string,
    input  logic                                         input_pc_valid,
    output logic                                         input_pc_ready,
    input  logic [CC_ID_BITS-1:0]                        input_cc_id,
    input  logic [PC_WIDTH-1:0]                          input_pc,
    output logic                                         memory_valid,
    input  logic                                         memory_ready,
    output logic [MEMORY_ADDR_WIDTH-1:0]                 memory_addr,
    input  logic [MEMORY_WIDTH-1:0]                      memory_data,
    output logic                                         output_pc_valid,
    input  logic                                         output_pc_ready,
    output logic [PC_WIDTH-1:0]                          output_pc,
    output logic [CC_ID_BITS-1:0]                        output_cc_id,
    output logic                                         accepts,
    output logic [(2**CC_ID_BITS)-1:0]                   elaborating_chars,
    output logic                                         running
);
    localparam int NCTX  = 2**CC_ID_BITS;
    localparam int DEPTH = 2**FIFO_WIDTH_POWER_OF_2;
    localparam int PTR_W = FIFO_WIDTH_POWER_OF_2;
    localparam int CNT_W = FIFO_WIDTH_POWER_OF_2 + 1;

    localparam logic [2:0] OP_ACCEPT         = 3'b000;
    localparam logic [2:0] OP_SPLIT          = 3'b001;
    localparam logic [2:0] OP_MATCH          = 3'b010;
    localparam logic [2:0] OP_JMP            = 3'b011;
    localparam logic [2:0] OP_END            = 3'b100;
    localparam logic [2:0] OP_MATCH_ANY      = 3'b101;
    localparam logic [2:0] OP_ACCEPT_PARTIAL = 3'b110;
    localparam logic [2:0] OP_NOT_MATCH      = 3'b111;

    localparam logic [PC_WIDTH-1:0]   PC_ONE    = PC_WIDTH'(1);
    localparam logic [CC_ID_BITS-1:0] CC_ONE    = CC_ID_BITS'(1);
    localparam logic [CNT_W-1:0]      DEPTH_C   = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]      TWO_SLOTS = CNT_W'(2);

    typedef struct packed {
        logic [CC_ID_BITS-1:0] cc;
        logic [PC_WIDTH-1:0]   pc;
    } thread_t;

    // Registered state and its next-state values.
    logic                    ready_q, ready_d;
    logic                    f_valid_q, f_valid_d;
    logic [PC_WIDTH-1:0]     f_pc_q, f_pc_d;
    logic [CC_ID_BITS-1:0]   f_cc_q, f_cc_d;
    logic                    p_valid_q, p_valid_d;   // fetch issued, data due next edge
    logic [PC_WIDTH-1:0]     p_pc_q, p_pc_d;
    logic [CC_ID_BITS-1:0]   p_cc_q, p_cc_d;
    logic                    e_valid_q, e_valid_d;
    logic [MEMORY_WIDTH-1:0] e_instr_q, e_instr_d;
    logic [PC_WIDTH-1:0]     e_pc_q, e_pc_d;
    logic [CC_ID_BITS-1:0]   e_cc_q, e_cc_d;
    thread_t                 fifo_q [DEPTH];
    thread_t                 fifo_d [DEPTH];
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic                    accepts_q, accepts_d;

    // Execute-stage decode results.
    logic [2:0]              opcode_s;
    logic [CHARACTER_WIDTH-1:0] ch_s;
    logic                    eos_s;
    logic [1:0]              n_push_s;
    thread_t                 push0_s, push1_s;
    logic                    accept_s;
    logic                    e_fire_s, in_fire_s, mem_fire_s, pop_s;

    assign e_fire_s        = e_valid_q && ((DEPTH_C - count_q) >= TWO_SLOTS);
    assign pop_s           = (count_q != '0) && output_pc_ready;
    assign input_pc_ready  = ready_q && !f_valid_q;
    assign in_fire_s       = input_pc_valid && input_pc_ready;
    // A new fetch waits until the slot for its data in E is guaranteed free.
    assign memory_valid    = f_valid_q && !p_valid_q && (!e_valid_q || e_fire_s);
    assign mem_fire_s      = memory_valid && memory_ready;
    assign memory_addr     = {{(MEMORY_ADDR_WIDTH-PC_WIDTH){1'b0}}, f_pc_q};
    assign output_pc_valid = (count_q != '0);
    assign output_pc       = fifo_q[rd_ptr_q].pc;
    assign output_cc_id    = fifo_q[rd_ptr_q].cc;
    assign accepts         = accepts_q;
    assign running         = f_valid_q || p_valid_q || e_valid_q || (count_q != '0);

    // Decode and execute the instruction held in E against its context.
    always_comb begin
        opcode_s = e_instr_q[MEMORY_WIDTH-1 -: 3];
        ch_s     = current_characters[int'(e_cc_q)*CHARACTER_WIDTH +: CHARACTER_WIDTH];
        eos_s    = end_of_string[e_cc_q];
        n_push_s = 2'd0;
        accept_s = 1'b0;
        push0_s  = '{cc: e_cc_q, pc: e_pc_q + PC_ONE};
        push1_s  = '{cc: e_cc_q, pc: e_instr_q[PC_WIDTH-1:0]};
        case (opcode_s)
            OP_ACCEPT: accept_s = eos_s;
            OP_SPLIT:  n_push_s = 2'd2;
            OP_MATCH: begin
                if (!eos_s && (ch_s == e_instr_q[CHARACTER_WIDTH-1:0])) begin
                    n_push_s = 2'd1;
                    push0_s  = '{cc: e_cc_q + CC_ONE, pc: e_pc_q + PC_ONE};
                end else begin
                    n_push_s = 2'd0;
                end
            end
            OP_JMP: begin
                n_push_s = 2'd1;
                push0_s  = '{cc: e_cc_q, pc: e_instr_q[PC_WIDTH-1:0]};
            end
            OP_END: n_push_s = 2'd0;
            OP_MATCH_ANY: begin
                if (!eos_s) begin
                    n_push_s = 2'd1;
                    push0_s  = '{cc: e_cc_q + CC_ONE, pc: e_pc_q + PC_ONE};
                end else begin
                    n_push_s = 2'd0;
                end
            end
`ifdef REGEX_CPU_ACCEPT_PARTIAL_EN
            OP_ACCEPT_PARTIAL: accept_s = 1'b1;
`else
            OP_ACCEPT_PARTIAL: accept_s = 1'b0;
`endif
            OP_NOT_MATCH: begin
                if (!eos_s && (ch_s != e_instr_q[CHARACTER_WIDTH-1:0])) begin
                    n_push_s = 2'd1;
                end else begin
                    n_push_s = 2'd0;
                end
            end
            default: n_push_s = 2'd0;
        endcase
    end

    // Advance threads through F, the pending fetch slot and E.
    always_comb begin
        ready_d   = 1'b1;
        f_valid_d = f_valid_q;
        f_pc_d    = f_pc_q;
        f_cc_d    = f_cc_q;
        if (in_fire_s) begin
            f_valid_d = 1'b1;
            f_pc_d    = input_pc;
            f_cc_d    = input_cc_id;
        end else if (mem_fire_s) begin
            f_valid_d = 1'b0;
        end else begin
            f_valid_d = f_valid_q;
        end
        p_valid_d = mem_fire_s;
        p_pc_d    = mem_fire_s ? f_pc_q : p_pc_q;
        p_cc_d    = mem_fire_s ? f_cc_q : p_cc_q;
        e_valid_d = e_valid_q;
        e_instr_d = e_instr_q;
        e_pc_d    = e_pc_q;
        e_cc_d    = e_cc_q;
        if (p_valid_q) begin
            e_valid_d = 1'b1;
            e_instr_d = memory_data;
            e_pc_d    = p_pc_q;
            e_cc_d    = p_cc_q;
        end else if (e_fire_s) begin
            e_valid_d = 1'b0;
        end else begin
            e_valid_d = e_valid_q;
        end
        accepts_d = e_fire_s && accept_s;
    end

    // Output FIFO: write successors of a firing E, pop on handshake.
    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = pop_s ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
        count_d  = count_q - (pop_s ? CNT_W'(1) : CNT_W'(0));
        if (e_fire_s && (n_push_s != 2'd0)) begin
            fifo_d[wr_ptr_q] = push0_s;
            if (n_push_s == 2'd2) begin
                fifo_d[wr_ptr_q + PTR_W'(1)] = push1_s;
            end else begin
                fifo_d[wr_ptr_q] = push0_s;
            end
            wr_ptr_d = wr_ptr_q + PTR_W'(n_push_s);
            count_d  = count_d + CNT_W'(n_push_s);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
    end

    // Per-context in-flight flags across every stage and live FIFO entry.
    always_comb begin : elab_calc
        logic             hit_v;
        logic [PTR_W-1:0] idx_v;
        elaborating_chars = '0;
        for (int k = 0; k < NCTX; k++) begin
            hit_v = (f_valid_q && (f_cc_q == CC_ID_BITS'(k)))
                 || (p_valid_q && (p_cc_q == CC_ID_BITS'(k)))
                 || (e_valid_q && (e_cc_q == CC_ID_BITS'(k)));
            for (int i = 0; i < DEPTH; i++) begin
                idx_v = rd_ptr_q + PTR_W'(i);
                hit_v = hit_v || ((CNT_W'(i) < count_q) && (fifo_q[idx_v].cc == CC_ID_BITS'(k)));
            end
            elaborating_chars[k] = hit_v;
        end
    end

    // State registers; reset discards every thread in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_q   <= 1'b0;
            f_valid_q <= 1'b0;
            f_pc_q    <= '0;
            f_cc_q    <= '0;
            p_valid_q <= 1'b0;
            p_pc_q    <= '0;
            p_cc_q    <= '0;
            e_valid_q <= 1'b0;
            e_instr_q <= '0;
            e_pc_q    <= '0;
            e_cc_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            accepts_q <= 1'b0;
        end else begin
            ready_q   <= ready_d;
            f_valid_q <= f_valid_d;
            f_pc_q    <= f_pc_d;
            f_cc_q    <= f_cc_d;
            p_valid_q <= p_valid_d;
            p_pc_q    <= p_pc_d;
            p_cc_q    <= p_cc_d;
            e_valid_q <= e_valid_d;
            e_instr_q <= e_instr_d;
            e_pc_q    <= e_pc_d;
            e_cc_q    <= e_cc_d;
            fifo_q    <= fifo_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            accepts_q <= accepts_d;
        end
    end
endmodule

// File: tb/tb_regex_cpu_pipelined.sv
// Directed testbench for regex_cpu_pipelined. Instruction memory is modelled
// by a single memory_data value that each scenario sets before issuing its
// thread; a negedge monitor records popped outputs and accepts pulses.
module tb_regex_cpu_pipelined;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] current_characters;
    logic [3:0]  end_of_string;
    logic        input_pc_valid;
    logic        input_pc_ready;
    logic [1:0]  input_cc_id;
    logic [8:0]  input_pc;
    logic        memory_valid;
    logic        memory_ready;
    logic [10:0] memory_addr;
    logic [15:0] memory_data;
    logic        output_pc_valid;
    logic        output_pc_ready;
    logic [8:0]  output_pc;
    logic [1:0]  output_cc_id;
    logic        accepts;
    logic [3:0]  elaborating_chars;
    logic        running;

    int checks = 0;
    int errors = 0;
    int acc_cnt = 0;
    logic [10:0] outq[$];

    always #5 clk = ~clk;

    regex_cpu_pipelined dut (
        .clk(clk), .rst(rst),
        .current_characters(current_characters), .end_of_string(end_of_string),
        .input_pc_valid(input_pc_valid), .input_pc_ready(input_pc_ready),
        .input_cc_id(input_cc_id), .input_pc(input_pc),
        .memory_valid(memory_valid), .memory_ready(memory_ready),
        .memory_addr(memory_addr), .memory_data(memory_data),
        .output_pc_valid(output_pc_valid), .output_pc_ready(output_pc_ready),
        .output_pc(output_pc), .output_cc_id(output_cc_id),
        .accepts(accepts), .elaborating_chars(elaborating_chars), .running(running)
    );

    // Record every popped output {cc_id, pc} and every cycle accepts is high.
    always @(negedge clk) begin
        if (rst && output_pc_valid && output_pc_ready) outq.push_back({output_cc_id, output_pc});
        if (accepts) acc_cnt++;
    end

    task tick;
        @(posedge clk);
        #1;
    endtask

    task send(input logic [8:0] pc, input logic [1:0] cc);
        int n;
        input_pc_valid = 1'b1;
        input_pc = pc;
        input_cc_id = cc;
        n = 0;
        while (!input_pc_ready && n < 50) begin tick; n++; end
        checks++;
        if (!input_pc_ready) begin errors++; $display("FAIL send_timeout ready=%0b required 1", input_pc_ready); end
        tick;
        input_pc_valid = 1'b0;
    endtask

    // Issue one thread and return once its instruction has been captured.
    task run_one(input logic [8:0] pc, input logic [1:0] cc, input logic [15:0] instr);
        int n;
        memory_data = instr;
        send(pc, cc);
        n = 0;
        while (!(memory_valid && memory_ready) && n < 50) begin tick; n++; end
        checks++;
        if (!memory_valid) begin errors++; $display("FAIL fetch_timeout memory_valid=%0b required 1", memory_valid); end
        tick;
        tick;
    endtask

    task wait_idle;
        int n;
        n = 0;
        while (running && n < 100) begin tick; n++; end
        checks++;
        if (running !== 1'b0) begin errors++; $display("FAIL idle_timeout running=%0b required 0", running); end
        tick;
    endtask

    task test_reset;
        rst = 1'b0;
        current_characters = 32'h41414141;
        end_of_string = 4'b0000;
        input_pc_valid = 1'b0; input_pc = 9'd0; input_cc_id = 2'd0;
        memory_ready = 1'b1; memory_data = 16'h0000; output_pc_ready = 1'b1;
        tick; tick;
        checks++;
        if ({input_pc_ready, memory_valid, output_pc_valid, accepts, running} !== 5'b00000) begin
            errors++; $display("FAIL reset_flags got %b required 00000", {input_pc_ready, memory_valid, output_pc_valid, accepts, running});
        end
        checks++;
        if ({elaborating_chars, memory_addr, output_pc, output_cc_id} !== 26'd0) begin
            errors++; $display("FAIL reset_values elab=%b addr=%0d pc=%0d cc=%0d required 0", elaborating_chars, memory_addr, output_pc, output_cc_id);
        end
        rst = 1'b1;
        repeat (30) tick;
        checks++;
        if ({running, output_pc_valid, memory_valid, input_pc_ready} !== 4'b0001) begin
            errors++; $display("FAIL idle_after_reset got %b required 0001", {running, output_pc_valid, memory_valid, input_pc_ready});
        end
    endtask

    task test_not_match_fail;
        outq.delete();
        memory_data = {3'b111, 13'h0041};
        input_pc_valid = 1'b1; input_pc = 9'd220; input_cc_id = 2'd2;
        tick;
        input_pc_valid = 1'b0;
        checks++;
        if (memory_valid !== 1'b1 || memory_addr !== 11'd220) begin
            errors++; $display("FAIL nm_fetch valid=%0b addr=%0d required 1/220", memory_valid, memory_addr);
        end
        tick;
        checks++;
        if (memory_valid !== 1'b0) begin errors++; $display("FAIL nm_fetch_drop memory_valid=%0b required 0", memory_valid); end
        tick;
        checks++;
        if (elaborating_chars !== 4'b0100 || running !== 1'b1) begin
            errors++; $display("FAIL nm_elab elab=%b running=%0b required 0100/1", elaborating_chars, running);
        end
        tick;
        checks++;
        if (running !== 1'b0) begin errors++; $display("FAIL nm_running running=%0b required 0", running); end
        repeat (5) tick;
        checks++;
        if (outq.size() != 0 || running !== 1'b0 || output_pc_valid !== 1'b0) begin
            errors++; $display("FAIL nm_no_output outputs=%0d running=%0b required 0/0", outq.size(), running);
        end
    endtask

    task test_not_match_pass;
        outq.delete();
        memory_data = {3'b111, 13'h0042};
        input_pc_valid = 1'b1; input_pc = 9'd220; input_cc_id = 2'd2;
        tick;
        input_pc_valid = 1'b0;
        tick; tick; tick;
        checks++;
        if (output_pc_valid !== 1'b1 || output_pc !== 9'd221 || output_cc_id !== 2'd2) begin
            errors++; $display("FAIL nmp_head valid=%0b pc=%0d cc=%0d required 1/221/2", output_pc_valid, output_pc, output_cc_id);
        end
        repeat (4) tick;
        checks++;
        if (outq.size() != 1 || running !== 1'b0) begin
            errors++; $display("FAIL nmp_count outputs=%0d running=%0b required 1/0", outq.size(), running);
        end else if (outq[0] !== {2'd2, 9'd221}) begin
            errors++; $display("FAIL nmp_value got %h required %h", outq[0], {2'd2, 9'd221});
        end
    endtask

    task test_match;
        outq.delete();
        run_one(9'd100, 2'd3, {3'b010, 13'h0041});
        run_one(9'd7, 2'd2, {3'b011, 13'd300});
        wait_idle;
        checks++;
        if (outq.size() != 2) begin
            errors++; $display("FAIL match_count got %0d required 2", outq.size());
        end else if (outq[0] !== {2'd0, 9'd101} || outq[1] !== {2'd2, 9'd300}) begin
            errors++; $display("FAIL match_values got %h %h required %h %h", outq[0], outq[1], {2'd0, 9'd101}, {2'd2, 9'd300});
        end
        outq.delete();
        end_of_string = 4'b1000;
        run_one(9'd100, 2'd3, {3'b010, 13'h0041});
        wait_idle;
        end_of_string = 4'b0000;
        checks++;
        if (outq.size() != 0) begin errors++; $display("FAIL match_eos outputs=%0d required 0", outq.size()); end
    endtask

    task test_split_stall;
        logic [10:0] exp_v [5];
        exp_v[0] = {2'd1, 9'd6};  exp_v[1] = {2'd1, 9'd40};
        exp_v[2] = {2'd1, 9'd11}; exp_v[3] = {2'd1, 9'd20};
        exp_v[4] = {2'd0, 9'd70};
        outq.delete();
        output_pc_ready = 1'b0;
        run_one(9'd5, 2'd1, {3'b001, 13'd40});
        run_one(9'd10, 2'd1, {3'b001, 13'd20});
        run_one(9'd30, 2'd0, {3'b011, 13'd70});
        repeat (4) tick;
        checks++;
        if (running !== 1'b1 || output_pc_valid !== 1'b1 || output_pc !== 9'd6 || output_cc_id !== 2'd1) begin
            errors++; $display("FAIL stall_head running=%0b valid=%0b pc=%0d cc=%0d required 1/1/6/1", running, output_pc_valid, output_pc, output_cc_id);
        end
        checks++;
        if (elaborating_chars !== 4'b0011) begin errors++; $display("FAIL stall_elab got %b required 0011", elaborating_chars); end
        output_pc_ready = 1'b1;
        wait_idle;
        checks++;
        if (outq.size() != 5) begin
            errors++; $display("FAIL split_count got %0d required 5", outq.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                if (outq[i] !== exp_v[i]) begin
                    errors++; $display("FAIL split_order idx %0d got %h required %h", i, outq[i], exp_v[i]);
                end
            end
        end
    endtask

    task test_accept;
        int exp_partial;
        acc_cnt = 0; outq.delete();
        end_of_string = 4'b0001;
        run_one(9'd9, 2'd0, 16'h0000);
        wait_idle; tick;
        checks++;
        if (acc_cnt != 1 || outq.size() != 0) begin
            errors++; $display("FAIL accept_eos pulses=%0d outputs=%0d required 1/0", acc_cnt, outq.size());
        end
        acc_cnt = 0;
        end_of_string = 4'b0000;
        run_one(9'd9, 2'd0, 16'h0000);
        wait_idle; tick;
        checks++;
        if (acc_cnt != 0 || outq.size() != 0) begin
            errors++; $display("FAIL accept_no_eos pulses=%0d outputs=%0d required 0/0", acc_cnt, outq.size());
        end
`ifdef REGEX_CPU_ACCEPT_PARTIAL_EN
        exp_partial = 1;
`else
        exp_partial = 0;
`endif
        acc_cnt = 0;
        run_one(9'd12, 2'd1, {3'b110, 13'd0});
        wait_idle; tick;
        checks++;
        if (acc_cnt != exp_partial || outq.size() != 0) begin
            errors++; $display("FAIL accept_partial pulses=%0d outputs=%0d required %0d/0", acc_cnt, outq.size(), exp_partial);
        end
    endtask

    task test_back_to_back;
        outq.delete();
        memory_data = {3'b101, 13'd0};
        send(9'd510, 2'd3);
        send(9'd511, 2'd3);
        send(9'd3, 2'd3);
        wait_idle;
        checks++;
        if (outq.size() != 3) begin
            errors++; $display("FAIL b2b_count got %0d required 3", outq.size());
        end else if (outq[0] !== {2'd0, 9'd511} || outq[1] !== {2'd0, 9'd0} || outq[2] !== {2'd0, 9'd4}) begin
            errors++; $display("FAIL b2b_values got %h %h %h required 1ff 000 004", outq[0], outq[1], outq[2]);
        end
    endtask

    task test_midreset;
        output_pc_ready = 1'b0;
        run_one(9'd5, 2'd1, {3'b001, 13'd40});
        tick;
        rst = 1'b0;
        tick;
        rst = 1'b1;
        tick;
        checks++;
        if (running !== 1'b0 || output_pc_valid !== 1'b0 || elaborating_chars !== 4'b0000) begin
            errors++; $display("FAIL midreset running=%0b valid=%0b elab=%b required 0/0/0000", running, output_pc_valid, elaborating_chars);
        end
        output_pc_ready = 1'b1;
    endtask

    initial begin
        test_reset;
        test_not_match_fail;
        test_not_match_pass;
        test_match;
        test_split_stall;
        test_accept;
        test_back_to_back;
        test_midreset;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
